// File: rtl/acl_sample_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acl_pkg
// Purpose  : ADXL345 register map, configuration values, controller state
//            encoding and the per-state transmit byte lookup.
// Revision : 1.0 - initial release
// ============================================================================
package acl_pkg;

    localparam logic [7:0] c_DATA_FORMAT_ADDR = 8'h31;
    localparam logic [7:0] c_POWER_CTL_ADDR   = 8'h2D;
    localparam logic [7:0] c_DATAX0_ADDR      = 8'h32;

    // +-2 g, 10-bit, right-justified; measurement mode
    localparam logic [7:0] c_DATA_FORMAT_VAL  = 8'h00;
    localparam logic [7:0] c_POWER_CTL_VAL    = 8'h08;

    // Read bit (7) and multi-byte bit (6) on top of the DATAX0 address
    localparam logic [7:0] c_READ_CMD         = 8'hC0 | c_DATAX0_ADDR;

    localparam logic [2:0] c_CFG_BYTES        = 3'd2;
    localparam logic [2:0] c_READ_BYTES       = 3'd7;

    typedef enum logic [2:0] {
        RST_WAIT = 3'd0,
        CFG_FMT  = 3'd1,
        CFG_PWR  = 3'd2,
        IDLE     = 3'd3,
        READ     = 3'd4,
        GAP      = 3'd5,
        LATCH    = 3'd6
    } acl_state_t;

    // Byte to shift out for position idx of the frame owned by state st
    function automatic logic [7:0] tx_byte(input acl_state_t st, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (st)
            CFG_FMT: b = (idx == 3'd0) ? c_DATA_FORMAT_ADDR : c_DATA_FORMAT_VAL;
            CFG_PWR: b = (idx == 3'd0) ? c_POWER_CTL_ADDR   : c_POWER_CTL_VAL;
            READ:    b = (idx == 3'd0) ? c_READ_CMD         : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acl_sample_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : acl_sample_ctrl_if
// Purpose  : Byte-level SPI engine handshake plus sensor chip select.
//            master = sampling controller, slave = byte engine.
// Revision : 1.0 - initial release
// ============================================================================
interface acl_sample_ctrl_if;
    logic       SPI_BUSY;
    logic       SPI_DONE;
    logic [7:0] SPI_RXDATA;
    logic       SPI_START;
    logic [7:0] SPI_TXDATA;
    logic       SS_N;

    modport master (
        output SPI_START, SPI_TXDATA, SS_N,
        input  SPI_BUSY, SPI_DONE, SPI_RXDATA
    );

    modport slave (
        input  SPI_START, SPI_TXDATA, SS_N,
        output SPI_BUSY, SPI_DONE, SPI_RXDATA
    );
endinterface
`default_nettype wire

// File: rtl/acl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : acl_tick_gen
// Purpose  : Free-running 0..SAMPLE_DIV-1 counter; one-cycle tick on wrap.
// Revision : 1.0 - initial release
// ============================================================================
module acl_tick_gen #(
    parameter int SAMPLE_DIV = 1_000_000
) (
    input  wire logic CLK,
    input  wire logic RST,
    output logic      o_tick
);
    localparam int              c_CW   = $clog2(SAMPLE_DIV);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SAMPLE_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    // Wrap counter; runs regardless of controller state
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/acl_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acl_sample_ctrl
// Purpose  : Configures an ADXL345 over a byte SPI engine, then burst-reads
//            DATAX0..DATAZ1 every sample tick and presents coherent 10-bit
//            axis words with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module acl_sample_ctrl
    import acl_pkg::*;
#(
    parameter int SAMPLE_DIV = 1_000_000,
    parameter int CS_GAP     = 16
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    acl_sample_ctrl_if.master  spi,
    output logic [9:0]         xAxis,
    output logic [9:0]         yAxis,
    output logic [9:0]         zAxis,
    output logic               DATA_VALID,
    output logic               CFG_DONE,
    output logic               OVERRUN
);
    localparam int              c_GW       = $clog2(CS_GAP + 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(CS_GAP - 1);

    acl_state_t      r_state;
    acl_state_t      r_gap_ret;     // where RST_WAIT/GAP go once SS_N idled long enough
    logic [c_GW-1:0] r_gap_cnt;
    logic [2:0]      r_idx;         // byte position inside current frame
    logic            r_xfer;        // one byte transfer outstanding
    logic            r_pending;
    logic [7:0]      r_x0, r_y0, r_z0;
    logic [1:0]      r_x1, r_y1;
    logic            r_ss_n;
    logic            r_start;
    logic [7:0]      r_txdata;
    logic [9:0]      r_x, r_y, r_z;
    logic            r_dv;
    logic            r_cfg_done;
    logic            r_ovr;

    logic            w_tick;
    logic [2:0]      w_nbytes;
    logic            w_last;

    acl_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .CLK    (CLK),
        .RST    (RST),
        .o_tick (w_tick)
    );

    assign w_nbytes = (r_state == READ) ? c_READ_BYTES : c_CFG_BYTES;
    assign w_last   = (r_idx == (w_nbytes - 3'd1));

    // Sequencer, byte handshake, tick bookkeeping and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= RST_WAIT;
            r_gap_ret  <= CFG_FMT;
            r_gap_cnt  <= '0;
            r_idx      <= 3'd0;
            r_xfer     <= 1'b0;
            r_pending  <= 1'b0;
            r_x0       <= 8'h00;
            r_y0       <= 8'h00;
            r_z0       <= 8'h00;
            r_x1       <= 2'b00;
            r_y1       <= 2'b00;
            r_ss_n     <= 1'b1;
            r_start    <= 1'b0;
            r_txdata   <= 8'h00;
            r_x        <= 10'd0;
            r_y        <= 10'd0;
            r_z        <= 10'd0;
            r_dv       <= 1'b0;
            r_cfg_done <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_dv    <= 1'b0;
            r_ovr   <= 1'b0;

            // A tick outside IDLE is remembered once; a second one is dropped
            if (w_tick && r_cfg_done && (r_state != IDLE)) begin
                if (r_pending) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end

            case (r_state)
                RST_WAIT, GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= r_gap_ret;
                        if (r_gap_ret == IDLE) begin
                            r_cfg_done <= 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (w_tick || r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= READ;
                    end
                end

                CFG_FMT, CFG_PWR, READ: begin
                    if (r_ss_n) begin
                        // Select the sensor a cycle ahead of the first byte
                        r_ss_n <= 1'b0;
                    end else if (r_xfer && spi.SPI_DONE) begin
                        r_xfer <= 1'b0;
                        if (r_state == READ) begin
                            case (r_idx)
                                3'd1:    r_x0 <= spi.SPI_RXDATA;
                                3'd2:    r_x1 <= spi.SPI_RXDATA[1:0];
                                3'd3:    r_y0 <= spi.SPI_RXDATA;
                                3'd4:    r_y1 <= spi.SPI_RXDATA[1:0];
                                3'd5:    r_z0 <= spi.SPI_RXDATA;
                                3'd6: begin
                                    r_x  <= {r_x1, r_x0};
                                    r_y  <= {r_y1, r_y0};
                                    r_z  <= {spi.SPI_RXDATA[1:0], r_z0};
                                    r_dv <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        if (w_last) begin
                            r_idx     <= 3'd0;
                            r_ss_n    <= 1'b1;
                            r_gap_ret <= (r_state == CFG_FMT) ? CFG_PWR : IDLE;
                            r_state   <= (r_state == READ) ? LATCH : GAP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else if (!r_xfer && !spi.SPI_BUSY) begin
                        r_start  <= 1'b1;
                        r_txdata <= tx_byte(r_state, r_idx);
                        r_xfer   <= 1'b1;
                    end
                end

                LATCH: begin
                    r_state <= GAP;
                end

                default: begin
                    r_state <= RST_WAIT;
                end
            endcase
        end
    end

    assign spi.SPI_START  = r_start;
    assign spi.SPI_TXDATA = r_txdata;
    assign spi.SS_N       = r_ss_n;
    assign xAxis          = r_x;
    assign yAxis          = r_y;
    assign zAxis          = r_z;
    assign DATA_VALID     = r_dv;
    assign CFG_DONE       = r_cfg_done;
    assign OVERRUN        = r_ovr;
endmodule
`default_nettype wire

// File: doc/acl_sample_ctrl.md
# acl_sample_ctrl

Periodic ADXL345 (PmodACL) sampling controller, directly upstream of the axis sign-magnitude converter. After reset it configures the sensor over a byte-level SPI master, then every sample period performs one 6-byte burst read of DATAX0..DATAZ1. It presents coherent 10-bit two's-complement xAxis/yAxis/zAxis words with a one-cycle valid strobe.

## Interface
- SAMPLE_DIV, 1_000_000: CLK cycles per sample tick (100 Hz at 100 MHz); must be ≥ 64
- CS_GAP, 16: CLK cycles SS_N held high between SPI transactions
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- SPI_BUSY  in  1  byte engine busy; high from cycle after SPI_START until SPI_DONE
- SPI_DONE  in  1  one-cycle pulse: byte shifted, SPI_RXDATA valid this cycle
- SPI_RXDATA  in  8  received byte
- SPI_START  out  1  one-cycle pulse requesting a byte transfer
- SPI_TXDATA  out  8  byte to send; stable from SPI_START until SPI_DONE
- SS_N  out  1  sensor chip select, active low
- xAxis, yAxis, zAxis  out  10 each  latest sample, two's complement
- DATA_VALID  out  1  one-cycle pulse when axis outputs update
- CFG_DONE  out  1  high once sensor configuration has completed
- OVERRUN  out  1  one-cycle pulse when a sample tick is dropped

## Operation
- States: RST_WAIT, CFG_FMT, CFG_PWR, IDLE, READ, GAP, LATCH.
- RST_WAIT: SS_N high for CS_GAP cycles, then CFG_FMT.
- CFG_FMT: SS_N low; bytes 0x31, 0x00 (DATA_FORMAT: ±2 g, 10-bit, right-justified); SS_N high; GAP; CFG_PWR.
- CFG_PWR: bytes 0x2D, 0x08 (POWER_CTL measure); SS_N high; GAP; set CFG_DONE; IDLE.
- IDLE: on tick (or pending tick) enter READ.
- READ: SS_N low; byte 0 = 0xF2 (read, multi-byte, addr 0x32), bytes 1..6 = 0x00; capture SPI_RXDATA of bytes 1..6 into X0,X1,Y0,Y1,Z0,Z1 shadow registers; after byte 6 → LATCH.
- LATCH: xAxis = {X1[1:0],X0}, yAxis = {Y1[1:0],Y0}, zAxis = {Z1[1:0],Z0}; DATA_VALID = 1; SS_N high; → GAP → IDLE.
- Byte handshake: SPI_START asserted only when SPI_BUSY = 0 and no transfer outstanding; at most one transfer outstanding; next START no earlier than cycle after SPI_DONE.
- SPI_DONE when no transfer outstanding: ignored.
- Tick generator: free-running counter 0..SAMPLE_DIV-1, tick on wrap; runs from reset, independent of state.
- Tick while not in IDLE: sets single-depth pending flag; tick while pending already set: dropped, OVERRUN pulses. Ticks before CFG_DONE do not set pending and do not pulse OVERRUN.
- Axis outputs change only in LATCH; all three update in the same cycle (never mixed samples).
- X1[7:2] etc. (sign extension bits) discarded.

## Timing
- Reset values: SS_N = 1, SPI_START = 0, SPI_TXDATA = 0x00, axes = 0, DATA_VALID = 0, CFG_DONE = 0, OVERRUN = 0, tick counter = 0, pending = 0.
- RST mid-transaction: all outputs at reset values the cycle after RST sampled high; SS_N released immediately; sequence restarts from RST_WAIT including configuration; later SPI_DONE from the aborted byte ignored.
- SS_N falls ≥ 1 cycle before first SPI_START of a transaction; rises the cycle after last SPI_DONE.
- Axis latency: outputs and DATA_VALID valid the cycle after SPI_DONE of byte 6.
- Tick arriving in the same cycle as LATCH: becomes pending (not overrun).
- Sample throughput limited by SPI engine; no tick is silently lost without OVERRUN after CFG_DONE.

## Structure
- Package acl_pkg: register addresses (DATA_FORMAT 0x31, POWER_CTL 0x2D, DATAX0 0x32), config values (0x00, 0x08), read command 0xF2, state enum, byte-count constants (2 config, 7 read).
- Sub-module acl_tick_gen: parameterised by SAMPLE_DIV, outputs one-cycle tick; the rest is one FSM plus shadow/output registers.

## Test plan
- Reset then SPI model with 20-cycle byte latency -> first bytes 0x31,0x00 then 0x2D,0x08, each pair framed by SS_N; CFG_DONE rises after second frame.
- Read returns X0..Z1 = 0x05,0xFF,0xFE,0x01,0x00,0x02 -> xAxis = 0x305, yAxis = 0x1FE, zAxis = 0x200, DATA_VALID one cycle, TX bytes 0xF2 then six 0x00.
- SAMPLE_DIV = 64, engine latency 20 -> two ticks during one read: first pending, second OVERRUN pulse; next read starts from IDLE immediately.
- RST asserted during byte 3 of a read -> SS_N high next cycle, axes 0, late SPI_DONE ignored, config sequence replays.
- Spurious SPI_DONE in IDLE and SPI_BUSY held high 10 extra cycles -> no capture, no SPI_START until SPI_BUSY low.
